// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//   Shared definitions for the calculator datapath: the default operand width
//   and the encoding used when choosing between operand A and operand B.
//   There are no ports; other files pull these in with `import calc_pkg::*`.
// -----------------------------------------------------------------------------
package calc_pkg;

  // Default operand / byte width used throughout the datapath.
  localparam int DATA_W = 8;

  // Default width of the per-output delivery counters.
  localparam int COUNT_W = 8;

  // Operand select encoding. This is shared with the 2:1 operand mux, so both
  // blocks agree on which side is A and which is B.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Pick the free flag of whichever side `sel` points at.
  function automatic logic sel_free(input logic sel,
                                    input logic a_free,
                                    input logic b_free);
    return (sel == SEL_A) ? a_free : b_free;
  endfunction

endpackage : calc_pkg

// File: rtl/out_slot_reg.sv
// -----------------------------------------------------------------------------
// out_slot_reg
//   One-entry valid/ready holding register with a wrap-around delivery counter.
//   A load and a drain can happen at the same edge, so the slot can sustain one
//   byte per cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high; clears data, valid, count
//   load       in   write load_data into the slot at this edge
//   load_data  in   [WIDTH-1:0] byte to store
//   out_ready  in   the sink consumes the held byte at this edge
//   out_data   out  [WIDTH-1:0] held byte
//   out_valid  out  the slot holds a byte
//   out_count  out  [CNT_W-1:0] number of bytes delivered (valid && ready)
//   free       out  the slot can take a load at this edge (empty or draining)
// -----------------------------------------------------------------------------
module out_slot_reg
  import calc_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             free
);

  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  assign drain = valid_q && out_ready;
  assign free  = !valid_q || out_ready;

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;

    if (drain) begin
      valid_d = 1'b0;
      count_d = count_q + CNT_W'(1);  // wraps naturally at 2^CNT_W
    end

    // A load at the same edge as a drain wins, so the slot stays valid with
    // the new byte and there is no bubble.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    // NOTE: the data register is reset too. It is a single visible output
    // register, not a memory array, and sinks see a_data/b_data = 0 after rst.
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_count = count_q;

endmodule : out_slot_reg

// File: rtl/demux_1x2_8bit_reg.sv
// -----------------------------------------------------------------------------
// demux_1x2_8bit_reg
//   Registered 1-to-2 demultiplexer. It steers a byte stream into operand
//   sink A or sink B. Each side has a one-entry valid/ready holding register.
//   In auto mode an internal ping-pong pointer alternates A, B, A, ... on every
//   accepted byte. Otherwise in_sel picks the side. If the chosen side is full
//   and not draining, the input stalls; it never falls back to the other side.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_data    in   [WIDTH-1:0] byte to route
//   in_valid   in   in_data is valid
//   in_ready   out  byte accepted this cycle (independent of in_valid)
//   in_sel     in   explicit target 0=A 1=B, used when auto_mode=0
//   auto_mode  in   target comes from the ping-pong pointer
//   a_data     out  [WIDTH-1:0] output A byte
//   a_valid    out  output A holds a byte
//   a_ready    in   sink A consumes
//   b_data     out  [WIDTH-1:0] output B byte
//   b_valid    out  output B holds a byte
//   b_ready    in   sink B consumes
//   next_sel   out  target of the next accepted transfer
//   a_count    out  [CNT_W-1:0] bytes delivered on A (wraps)
//   b_count    out  [CNT_W-1:0] bytes delivered on B (wraps)
// -----------------------------------------------------------------------------
module demux_1x2_8bit_reg
  import calc_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic             auto_mode,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             next_sel,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic ptr_q, ptr_d;
  logic tgt;
  logic a_free, b_free;
  logic accept;
  logic load_a, load_b;

  // The pointer only steers while auto_mode is high. Leaving auto mode freezes
  // it, so re-entering auto mode resumes the alternation where it stopped.
  assign tgt      = auto_mode ? ptr_q : in_sel;
  assign next_sel = tgt;

  // rst gates in_ready combinationally, so no byte is ever accepted during a
  // reset cycle.
  assign in_ready = !rst && sel_free(tgt, a_free, b_free);
  assign accept   = in_valid && in_ready;
  assign load_a   = accept && (tgt == SEL_A);
  assign load_b   = accept && (tgt == SEL_B);

  always_comb begin
    ptr_d = ptr_q;
    if (auto_mode && accept) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SEL_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  out_slot_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .load_data (in_data),
    .out_ready (a_ready),
    .out_data  (a_data),
    .out_valid (a_valid),
    .out_count (a_count),
    .free      (a_free)
  );

  out_slot_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .load_data (in_data),
    .out_ready (b_ready),
    .out_data  (b_data),
    .out_valid (b_valid),
    .out_count (b_count),
    .free      (b_free)
  );

endmodule : demux_1x2_8bit_reg

// File: tb/tb_demux_1x2_8bit_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1x2_8bit_reg
//   Directed scenarios plus a randomized run, checked against a behavioural
//   model of the demux: two one-byte mailboxes, a pointer and delivery tallies.
// -----------------------------------------------------------------------------
module tb_demux_1x2_8bit_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel;
  logic       auto_mode;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic       next_sel;
  logic [7:0] a_count;
  logic [7:0] b_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: index 0 = A, 1 = B.
  bit       m_full [2];
  bit [7:0] m_byte [2];
  int       m_delivered [2];
  int       m_ptr;

  always #5 clk = ~clk;

  demux_1x2_8bit_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .auto_mode (auto_mode),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .next_sel  (next_sel),
    .a_count   (a_count),
    .b_count   (b_count)
  );

  function automatic int model_target();
    return auto_mode ? m_ptr : int'(in_sel);
  endfunction

  function automatic bit model_ready();
    int t;
    bit sink_rdy;
    t = model_target();
    sink_rdy = (t == 0) ? a_ready : b_ready;
    return !rst && (!m_full[t] || sink_rdy);
  endfunction

  // Advance one clock: update the model from the inputs present at the edge,
  // then move 1 time unit past the edge so outputs are sampled clear of it.
  task automatic step();
    bit take;
    bit sink_rdy [2];
    int t;
    @(posedge clk);
    take = in_valid && model_ready();
    t = model_target();
    sink_rdy[0] = a_ready;
    sink_rdy[1] = b_ready;
    if (rst) begin
      m_full = '{0, 0};
      m_byte = '{8'h00, 8'h00};
      m_delivered = '{0, 0};
      m_ptr = 0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (m_full[s] && sink_rdy[s]) begin
          m_full[s] = 0;
          m_delivered[s] = (m_delivered[s] + 1) % 256;
        end
      end
      if (take) begin
        m_full[t] = 1;
        m_byte[t] = in_data;
        if (auto_mode) m_ptr = 1 - m_ptr;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_sel = 1'b0;
    auto_mode = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({a_valid, b_valid, a_data, b_data, a_count, b_count, next_sel} !== '0) begin
      failures++;
      $display("FAIL reset_state got av=%b bv=%b ad=%h bd=%h ac=%h bc=%h ns=%b want all 0",
               a_valid, b_valid, a_data, b_data, a_count, b_count, next_sel);
    end
  endtask

  task automatic test_explicit();
    auto_mode = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h12;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL explicit_rdy0 got=%b want=1", in_ready); end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h12) begin
      failures++; $display("FAIL explicit_a got v=%b d=%h want v=1 d=12", a_valid, a_data);
    end
    in_sel = 1'b1; in_data = 8'h34;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL explicit_rdy1 got=%b want=1", in_ready); end
    step();
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h34 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL explicit_b got bv=%b bd=%h av=%b want bv=1 bd=34 av=0", b_valid, b_data, a_valid);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (a_count !== 8'd1 || b_count !== 8'd1) begin
      failures++; $display("FAIL explicit_counts got a=%0d b=%0d want a=1 b=1", a_count, b_count);
    end
  endtask

  task automatic test_ping_pong();
    bit [7:0] got;
    bit       vld;
    auto_mode = 1'b1; a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1);
      #1;
      checks++;
      if (next_sel !== 1'(i % 2) || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL pingpong_sel[%0d] got ns=%b rdy=%b want ns=%0d rdy=1", i, next_sel, in_ready, i % 2);
      end
      step();
      got = (i % 2 == 0) ? a_data : b_data;
      vld = (i % 2 == 0) ? a_valid : b_valid;
      checks++;
      if (vld !== 1'b1 || got !== 8'(i + 1)) begin
        failures++; $display("FAIL pingpong_data[%0d] got v=%b d=%h want v=1 d=%h", i, vld, got, 8'(i + 1));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bit [7:0] cnt_before;
    auto_mode = 1'b0; in_sel = 1'b0; a_ready = 1'b0; b_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h55;
    step();
    in_data = 8'h66;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_blocked got rdy=%b want=0", in_ready); end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h55) begin
      failures++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=55", a_valid, a_data);
    end
    cnt_before = a_count;
    a_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got rdy=%b want=1", in_ready); end
    step();
    a_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h66 || a_count !== cnt_before + 8'd1) begin
      failures++;
      $display("FAIL bp_swap got v=%b d=%h cnt=%0d want v=1 d=66 cnt=%0d",
               a_valid, a_data, a_count, cnt_before + 8'd1);
    end
  endtask

  task automatic test_independence();
    b_ready = 1'b0; a_ready = 1'b0; auto_mode = 1'b0;
    in_sel = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL indep_rdy got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h77 || a_valid !== 1'b1 || a_data !== 8'h66) begin
      failures++;
      $display("FAIL indep_state got bv=%b bd=%h av=%b ad=%h want bv=1 bd=77 av=1 ad=66",
               b_valid, b_data, a_valid, a_data);
    end
    auto_mode = 1'b1;
    #1;
    checks++;
    if (next_sel !== 1'b0) begin failures++; $display("FAIL indep_ptr got=%b want=0", next_sel); end
  endtask

  task automatic test_reset_mid();
    // A drains and reloads 0x88 in auto mode, so the pointer moves to B.
    a_ready = 1'b1; b_ready = 1'b0; auto_mode = 1'b1;
    in_valid = 1'b1; in_data = 8'h88;
    step();
    a_ready = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (next_sel !== 1'b1 || a_valid !== 1'b1 || b_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre got ns=%b av=%b bv=%b want ns=1 av=1 bv=1", next_sel, a_valid, b_valid);
    end
    rst = 1'b1; in_valid = 1'b1; b_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_rdy got=%b want=0", in_ready); end
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_count !== 8'd0 || b_count !== 8'd0 || next_sel !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_post got av=%b bv=%b ac=%0d bc=%0d ns=%b want 0 0 0 0 0",
               a_valid, b_valid, a_count, b_count, next_sel);
    end
  endtask

  task automatic test_counter_wrap();
    auto_mode = 1'b0; in_sel = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'($urandom);
      step();
      // After i+1 edges with a byte in flight, i bytes have been delivered.
      if (i == 199 || i == 255) begin
        checks++;
        if (a_count !== 8'(i)) begin
          failures++; $display("FAIL wrap_mid[%0d] got=%0d want=%0d", i, a_count, i);
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (a_count !== 8'h00 || b_count !== 8'h00) begin
      failures++; $display("FAIL wrap_end got a=%0d b=%0d want a=0 b=0", a_count, b_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(63) == 0);
      in_data   = 8'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      in_sel    = 1'($urandom);
      auto_mode = ($urandom_range(4) != 0);
      a_ready   = ($urandom_range(2) != 0);
      b_ready   = ($urandom_range(2) != 0);
      #1;
      checks++;
      if (in_ready !== model_ready() || next_sel !== 1'(model_target())) begin
        failures++;
        $display("FAIL rand_comb[%0d] got rdy=%b ns=%b want rdy=%b ns=%0d",
                 n, in_ready, next_sel, model_ready(), model_target());
      end
      step();
      checks++;
      if (a_valid !== m_full[0] || b_valid !== m_full[1] ||
          a_data !== m_byte[0] || b_data !== m_byte[1] ||
          a_count !== 8'(m_delivered[0]) || b_count !== 8'(m_delivered[1])) begin
        failures++;
        $display("FAIL rand_state[%0d] got av=%b ad=%h ac=%0d bv=%b bd=%h bc=%0d want av=%b ad=%h ac=%0d bv=%b bd=%h bc=%0d",
                 n, a_valid, a_data, a_count, b_valid, b_data, b_count,
                 m_full[0], m_byte[0], m_delivered[0], m_full[1], m_byte[1], m_delivered[1]);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    m_full = '{0, 0};
    m_byte = '{8'h00, 8'h00};
    m_delivered = '{0, 0};
    m_ptr = 0;
    test_reset();
    test_explicit();
    test_ping_pong();
    test_backpressure();
    test_independence();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_1x2_8bit_reg

// File: doc/demux_1x2_8bit_reg.md
Name: demux_1x2_8bit_reg

Overview:
- Registered 1-to-2 demultiplexer. It steers a byte stream from one source into one of two operand sinks (A or B).
- It is the distribution counterpart of the 2:1 operand select in the calculator datapath. Keypad or switch bytes enter on one port and leave on the A or B side.
- Each output has a one-entry holding register with valid/ready handshake.
- In auto mode the block ping-pongs between A and B, so consecutive entries fill operand A, then B, then A, and so on.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- CNT_W, 8, width of the per-output transfer counters (wrap-around).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  byte to route.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_sel  input  1  explicit target, 0=A, 1=B. Used only when auto_mode=0.
- auto_mode  input  1  1 = target comes from the internal ping-pong pointer.
- a_data  output  WIDTH  output A data.
- a_valid  output  1  output A holds a byte.
- a_ready  input  1  sink A consumes the byte.
- b_data  output  WIDTH  output B data.
- b_valid  output  1  output B holds a byte.
- b_ready  input  1  sink B consumes the byte.
- next_sel  output  1  target of the next accepted transfer (pointer in auto mode, in_sel otherwise).
- a_count  output  CNT_W  bytes delivered on A (count of a_valid&&a_ready).
- b_count  output  CNT_W  bytes delivered on B.

Behaviour:
- Reset (rst=1 at posedge) clears all state:
  - a_valid=0, b_valid=0, a_data=0, b_data=0.
  - Pointer=0 (A), a_count=0, b_count=0.
  - Any in-flight byte is discarded.
  - in_ready is 0 during any cycle with rst=1.
- Target select: tgt = auto_mode ? ptr : in_sel. next_sel = tgt (combinational).
- Slot free (combinational): slot_X_free = !X_valid || X_ready.
- in_ready = !rst && slot_tgt_free. This is combinational from auto_mode, in_sel, ptr, X_valid and X_ready. in_ready does not depend on in_valid.
- Accept event: in_valid && in_ready. At that posedge:
  - X_data <= in_data and X_valid <= 1 for X = tgt.
  - The other output is unaffected.
- Latency: a byte accepted at edge N shows X_valid=1 from edge N onward, i.e. visible in cycle N+1.
- Drain: X_valid && X_ready at a posedge clears X_valid, unless an accept to X happens at the same edge. In that case X_valid stays 1 with the new data. This gives full throughput of one byte per cycle per side.
- Hold: while X_valid && !X_ready, X_data and X_valid are stable. A byte is never overwritten or dropped.
- Pointer:
  - In auto mode, ptr toggles on every accept event.
  - When auto_mode=0, ptr holds its value.
  - Switching auto_mode mid-stream does not reset ptr.
- Counters: X_count increments by 1 on each X_valid && X_ready edge and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - Accept to A and drain of B in the same cycle are independent.
  - A drain and accept on the same side behave as described under Drain.
- Blocked target: if the target slot is full and not draining, in_ready=0. The other side is not used as a fallback. The pointer does not advance.
- Reset mid-operation: held bytes are lost and counters clear. Sinks must not rely on a byte after rst.

Decomposition:
- Shared package calc_pkg:
  - DATA_W=8.
  - Select encoding localparams SEL_A=1'b0 and SEL_B=1'b1.
- Natural sub-module: out_slot_reg.
  - One-entry valid/ready holding register with load, drain and delivery counter.
  - Instantiated twice (A and B).
- Top level holds the ptr flop, target select and in_ready logic.

Test Plan:
- Explicit routing: auto_mode=0, a_ready=b_ready=1. Send 0x12 (sel=0), then 0x34 (sel=1) → a_data=0x12 one cycle later, b_data=0x34 next. a_count=1, b_count=1. in_ready stays 1.
- Ping-pong: auto_mode=1, both ready. Stream 0x01,0x02,0x03,0x04 back-to-back → A gets 0x01,0x03 and B gets 0x02,0x04. next_sel toggles 0,1,0,1. Full throughput with no bubbles.
- Backpressure: auto_mode=0, sel=0, a_ready=0. Send 0x55 then 0x66 → a_data holds 0x55 and in_ready=0 for 0x66. Raising a_ready for one cycle drains 0x55 and loads 0x66 at the same edge, and a_valid stays 1.
- Independence: a_ready=0 with A full, sel=1, send 0x77 → accepted into B while A still holds its byte. The ptr/A state is unchanged.
- Counter wrap: CNT_W=8, deliver 256 bytes on A → a_count returns to 0x00. b_count is unchanged.
- Reset mid-stream: both slots full and ptr=1, assert rst one cycle → a_valid=b_valid=0, counts=0, next_sel=0 in auto mode, in_ready=0 during the rst cycle.
